// File: rtl/fifo_arb_pkg.sv
// Shared state type and sizing helpers for the fifo_arb_ctrl write arbiter
// and read sequencer; the defaults match the fifo_mem instances it fronts.
package fifo_arb_pkg;
  localparam int DW_DEFAULT    = 8;
  localparam int DEPTH_DEFAULT = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int idx_w(input int nreq);
    return (nreq < 2) ? 1 : $clog2(nreq);
  endfunction

  localparam int LEVEL_W = level_w(DEPTH_DEFAULT);
  localparam int IDX_W   = idx_w(2);
endpackage

// File: rtl/fifo_arb_ctrl_rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after rr_ptr,
// wrapping modulo NREQ.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    // Scan farthest-first so the requester nearest rr_ptr is the last write.
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = (int'(rr_ptr) + off) % NREQ;
      if (req[IW'(cand)]) begin
        idx = IW'(cand);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_arb_ctrl.sv
// Write-port arbiter with bounded round-robin bursts, valid/ready drain and
// an occupancy cross-check against the fifo_mem flags.
//   state | meaning
//   IDLE  | sample requests, pick next owner, no grant
//   GRANT | owner writes up to BURST beats, stalls while fifo_full
module fifo_arb_ctrl
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DW-1:0]        req_data,
  output logic [NREQ-1:0]           gnt,
  output logic                      fifo_rst_n,
  output logic                      fifo_wr,
  output logic [DW-1:0]             fifo_din,
  output logic                      fifo_rd,
  input  logic [DW-1:0]             fifo_dout,
  input  logic                      fifo_full,
  input  logic                      fifo_empty,
  input  logic                      fifo_overflow,
  input  logic                      fifo_underflow,
  output logic                      out_valid,
  output logic [DW-1:0]             out_data,
  input  logic                      out_ready,
  output logic [level_w(DEPTH)-1:0] level,
  output logic                      err
);

  localparam int LW = level_w(DEPTH);
  localparam int IW = idx_w(NREQ);
  localparam int BW = $clog2(BURST + 1);

  arb_state_t    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] next_ptr;
  logic [IW-1:0] arb_idx;
  logic [BW-1:0] beat_cnt;
  logic          arb_any;
  logic          owner_req;
  logic          beat_ok;
  logic          last_beat;
  logic          burst_done;
  logic          flag_mismatch;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arbiter (
    .req    (req),
    .rr_ptr (rr_ptr),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  // A reset cycle must not push a beat the FIFO is about to discard.
  assign owner_req  = req[owner];
  assign beat_ok    = !rst && (state == GRANT) && owner_req && !fifo_full
                      && (beat_cnt < BW'(BURST));
  assign last_beat  = beat_ok && (beat_cnt == BW'(BURST - 1));
  assign burst_done = last_beat || !owner_req;
  assign next_ptr   = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);

  assign fifo_rst_n = ~rst;
  assign fifo_wr    = beat_ok;
  assign fifo_din   = req_data[int'(owner)*DW +: DW];

  always_comb begin
    gnt        = '0;
    gnt[owner] = beat_ok;
  end

  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_dout;
  assign fifo_rd   = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            owner    <= arb_idx;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (beat_ok) beat_cnt <= beat_cnt + BW'(1);
          if (burst_done) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
    end else if (fifo_wr && !fifo_rd) begin
      level <= level + LW'(1);
    end else if (fifo_rd && !fifo_wr) begin
      level <= level - LW'(1);
    end
  end

  assign flag_mismatch = ((level == LW'(DEPTH)) != fifo_full)
                       || ((level == '0) != fifo_empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (fifo_overflow || fifo_underflow || flag_mismatch) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Bench for fifo_arb_ctrl with a behavioural FWFT FIFO, a scoreboard of
// written words and a request-level arbitration model.
module tb_fifo_arb_ctrl;
  localparam int NREQ  = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int BURST = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     gnt;
  logic [NREQ*DW-1:0]  req_data;
  logic                fifo_rst_n;
  logic                fifo_wr;
  logic [DW-1:0]       fifo_din;
  logic                fifo_rd;
  logic [DW-1:0]       fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_overflow;
  logic                fifo_underflow;
  logic                out_valid;
  logic [DW-1:0]       out_data;
  logic                out_ready;
  logic [4:0]          level;
  logic                err;

  always #5 clk = ~clk;

  fifo_arb_ctrl #(
    .NREQ  (NREQ),
    .DW    (DW),
    .DEPTH (DEPTH),
    .BURST (BURST)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_data       (req_data),
    .gnt            (gnt),
    .fifo_rst_n     (fifo_rst_n),
    .fifo_wr        (fifo_wr),
    .fifo_din       (fifo_din),
    .fifo_rd        (fifo_rd),
    .fifo_dout      (fifo_dout),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .fifo_overflow  (fifo_overflow),
    .fifo_underflow (fifo_underflow),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .level          (level),
    .err            (err)
  );

  // Behavioural fifo_mem: first-word-fall-through, synchronous active-low reset.
  logic [DW-1:0] fmem [DEPTH];
  logic [3:0]    fwp   = '0;
  logic [3:0]    frp   = '0;
  logic [4:0]    fcnt  = '0;
  logic          f_ovf = 1'b0;
  logic          f_unf = 1'b0;
  logic          force_ne = 1'b0;
  logic          wr_ok, rd_ok;

  assign wr_ok          = fifo_wr && (fcnt != 5'd16);
  assign rd_ok          = fifo_rd && (fcnt != 5'd0);
  assign fifo_full      = (fcnt == 5'd16);
  assign fifo_empty     = (fcnt == 5'd0) && !force_ne;
  assign fifo_dout      = fmem[frp];
  assign fifo_overflow  = f_ovf;
  assign fifo_underflow = f_unf;

  always @(posedge clk) begin
    if (!fifo_rst_n) begin
      fcnt  <= '0;
      fwp   <= '0;
      frp   <= '0;
      f_ovf <= 1'b0;
      f_unf <= 1'b0;
    end else begin
      f_ovf <= fifo_wr && (fcnt == 5'd16);
      f_unf <= fifo_rd && (fcnt == 5'd0);
      if (wr_ok) begin
        fmem[fwp] <= fifo_din;
        fwp       <= fwp + 4'd1;
      end
      if (rd_ok) frp <= frp + 4'd1;
      fcnt <= fcnt + {4'b0, wr_ok} - {4'b0, rd_ok};
    end
  end

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] sb [$];
  int            pend [NREQ];
  logic [DW-1:0] nxt  [NREQ];
  int            m_owner, m_rr, m_beats;
  logic          m_err;
  logic [NREQ-1:0] w;

  typedef struct {
    logic          want0;
    logic          ordy;
    logic [1:0]    gnt;
    int            lvl;
    logic          vld;
    logic [DW-1:0] dat;
  } vec_t;

  vec_t            tbl  [16];
  logic [NREQ-1:0] cpat [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, check combinational outputs against
  // the model, then advance producers, scoreboard and model for the next edge.
  task automatic cycle(input logic [NREQ-1:0] want, input logic ordy,
                       input logic do_rst, input logic fne);
    logic [NREQ-1:0] exp_gnt;
    int n;
    @(negedge clk);
    rst       = do_rst;
    force_ne  = fne;
    out_ready = ordy;
    for (int i = 0; i < NREQ; i++) begin
      req[i]               = want[i] && (pend[i] > 0);
      req_data[i*DW +: DW] = nxt[i];
    end
    #1;
    n       = sb.size();
    exp_gnt = '0;
    if (!do_rst && m_owner >= 0 && req[m_owner] && n < DEPTH && m_beats < BURST)
      exp_gnt[m_owner] = 1'b1;
    check("gnt", gnt, exp_gnt);
    check("fifo_wr", fifo_wr, |exp_gnt);
    check("level", level, n);
    check("out_valid", out_valid, (n != 0) || fne);
    check("fifo_rd", fifo_rd, ((n != 0) || fne) && ordy);
    if (n != 0) check("out_data", out_data, sb[0]);
    check("err", err, m_err);
    check("overflow", fifo_overflow, 1'b0);
    check("underflow", fifo_underflow, 1'b0);

    if (do_rst) begin
      sb.delete();
      m_owner = -1;
      m_rr    = 0;
      m_beats = 0;
      m_err   = 1'b0;
    end else begin
      if (n != 0 && ordy) void'(sb.pop_front());
      if (m_owner >= 0 && exp_gnt != 0) sb.push_back(nxt[m_owner]);
      if (fne && n == 0) m_err = 1'b1;
      if (m_owner < 0) begin
        for (int k = 0; k < NREQ; k++)
          if (m_owner < 0 && req[(m_rr + k) % NREQ]) begin
            m_owner = (m_rr + k) % NREQ;
            m_beats = 0;
          end
      end else begin
        if (exp_gnt != 0) m_beats++;
        if (m_beats == BURST || !req[m_owner]) begin
          m_rr    = (m_owner + 1) % NREQ;
          m_owner = -1;
        end
      end
    end
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) begin
        pend[i]--;
        nxt[i] = nxt[i] + 8'd1;
      end
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0; out_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin pend[i] = 0; nxt[i] = '0; end
    m_owner = -1; m_rr = 0; m_beats = 0; m_err = 1'b0;

    // Single requester: bursts of 4, one IDLE, 2 more, then drain.
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 2'd1, 0, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 2'd1, 1, 1'b1, 8'h01};
    tbl[3]  = '{1'b1, 1'b0, 2'd1, 2, 1'b1, 8'h01};
    tbl[4]  = '{1'b1, 1'b0, 2'd1, 3, 1'b1, 8'h01};
    tbl[5]  = '{1'b1, 1'b0, 2'd0, 4, 1'b1, 8'h01};
    tbl[6]  = '{1'b1, 1'b0, 2'd1, 4, 1'b1, 8'h01};
    tbl[7]  = '{1'b1, 1'b0, 2'd1, 5, 1'b1, 8'h01};
    tbl[8]  = '{1'b1, 1'b0, 2'd0, 6, 1'b1, 8'h01};
    tbl[9]  = '{1'b0, 1'b1, 2'd0, 6, 1'b1, 8'h01};
    tbl[10] = '{1'b0, 1'b1, 2'd0, 5, 1'b1, 8'h02};
    tbl[11] = '{1'b0, 1'b1, 2'd0, 4, 1'b1, 8'h03};
    tbl[12] = '{1'b0, 1'b1, 2'd0, 3, 1'b1, 8'h04};
    tbl[13] = '{1'b0, 1'b1, 2'd0, 2, 1'b1, 8'h05};
    tbl[14] = '{1'b0, 1'b1, 2'd0, 1, 1'b1, 8'h06};
    tbl[15] = '{1'b0, 1'b0, 2'd0, 0, 1'b0, 8'h00};
    cpat = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2,
             2'd0, 2'd1, 2'd1, 2'd1, 2'd1};

    cycle(2'b00, 1'b0, 1'b1, 1'b0);
    cycle(2'b00, 1'b0, 1'b1, 1'b0);
    cycle(2'b00, 1'b0, 1'b0, 1'b0);
    check("rst_gnt", gnt, 2'b00);
    check("rst_level", level, 0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_err", err, 1'b0);

    pend[0] = 6; nxt[0] = 8'h01;
    for (int t = 0; t < 16; t++) begin
      cycle({1'b0, tbl[t].want0}, tbl[t].ordy, 1'b0, 1'b0);
      check("tbl_gnt", gnt, tbl[t].gnt);
      check("tbl_level", level, tbl[t].lvl);
      check("tbl_valid", out_valid, tbl[t].vld);
      if (tbl[t].vld) check("tbl_data", out_data, tbl[t].dat);
    end

    // Contention: alternating bursts of 4 from a fresh rr pointer.
    cycle(2'b00, 1'b0, 1'b1, 1'b0);
    pend[0] = 100; pend[1] = 100; nxt[0] = 8'h10; nxt[1] = 8'h80;
    for (int t = 0; t < 15; t++) begin
      cycle(2'b11, 1'b1, 1'b0, 1'b0);
      check("contend_gnt", gnt, cpat[t]);
    end
    for (int t = 0; t < 6; t++) cycle(2'b00, 1'b1, 1'b0, 1'b0);

    // Fill: 17 offered, 16 accepted, stall on full, then drain.
    cycle(2'b00, 1'b0, 1'b1, 1'b0);
    pend[0] = 17; nxt[0] = 8'h40;
    for (int t = 0; t < 26; t++) cycle(2'b01, 1'b0, 1'b0, 1'b0);
    check("fill_full", fifo_full, 1'b1);
    check("fill_level", level, 16);
    check("fill_gnt", gnt, 2'b00);
    check("fill_err", err, 1'b0);
    cycle(2'b00, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 17; t++) cycle(2'b00, 1'b1, 1'b0, 1'b0);
    check("drain_level", level, 0);

    // Simultaneous write and pop at level 5.
    cycle(2'b00, 1'b0, 1'b1, 1'b0);
    pend[0] = 5; nxt[0] = 8'h20;
    for (int t = 0; t < 8; t++) cycle(2'b01, 1'b0, 1'b0, 1'b0);
    cycle(2'b00, 1'b0, 1'b0, 1'b0);
    check("rw_level_pre", level, 5);
    pend[0] = 1;
    cycle(2'b01, 1'b0, 1'b0, 1'b0);
    cycle(2'b01, 1'b1, 1'b0, 1'b0);
    check("rw_both", {fifo_wr, fifo_rd}, 2'b11);
    cycle(2'b00, 1'b0, 1'b0, 1'b0);
    check("rw_level_post", level, 5);

    // Reset in the middle of requester 1's burst.
    cycle(2'b00, 1'b0, 1'b1, 1'b0);
    pend[0] = 4; nxt[0] = 8'h30;
    for (int t = 0; t < 5; t++) cycle(2'b01, 1'b0, 1'b0, 1'b0);
    pend[0] = 10; pend[1] = 10; nxt[1] = 8'hA0;
    cycle(2'b11, 1'b0, 1'b0, 1'b0);
    cycle(2'b11, 1'b0, 1'b0, 1'b0);
    check("mid_owner1", gnt, 2'b10);
    cycle(2'b11, 1'b0, 1'b0, 1'b0);
    cycle(2'b11, 1'b0, 1'b1, 1'b0);
    cycle(2'b11, 1'b0, 1'b0, 1'b0);
    check("mid_gnt", gnt, 2'b00);
    check("mid_wr", fifo_wr, 1'b0);
    check("mid_level", level, 0);
    check("mid_err", err, 1'b0);
    check("mid_valid", out_valid, 1'b0);
    cycle(2'b11, 1'b0, 1'b0, 1'b0);
    check("mid_next_owner", gnt, 2'b01);

    // Error injection: non-empty flag while level is zero.
    cycle(2'b00, 1'b0, 1'b1, 1'b0);
    cycle(2'b00, 1'b0, 1'b0, 1'b1);
    check("inj_err_before", err, 1'b0);
    cycle(2'b00, 1'b0, 1'b0, 1'b0);
    check("inj_err_rise", err, 1'b1);
    for (int t = 0; t < 3; t++) begin
      cycle(2'b00, 1'b0, 1'b0, 1'b0);
      check("inj_err_hold", err, 1'b1);
    end
    cycle(2'b00, 1'b0, 1'b1, 1'b0);
    cycle(2'b00, 1'b0, 1'b0, 1'b0);
    check("inj_err_clear", err, 1'b0);

    // Randomized traffic against the model.
    w = '1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0) w[i] = ~w[i];
        if (pend[i] <= 0 && $urandom_range(0, 3) == 0) pend[i] = $urandom_range(1, 9);
      end
      cycle(w, ($urandom_range(0, 99) < (((c / 150) % 2 == 1) ? 20 : 80)), 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
